aes_status_monitor: RTL and testbench

Self-checking run monitor sitting on the status side of the AES wrapper. It consumes the `ready`, `key_exp_done`, `result_valid` and `result_correct` indications the wrapper produces. It sequences through one armed run, counts correct and incorrect results, and enforces per-phase timeouts and protocol ordering. It presents a single latched pass/fail verdict for benches and on-chip BIST readout.

---
 rtl/aes_status_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_aes_status_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_status_monitor.sv
// aes_status_monitor
//   Watches the status side of the AES wrapper through one armed run. It
//   counts correct and incorrect results, checks event ordering and enforces a
//   per-phase timeout. It then latches a single pass/fail verdict together
//   with the first error seen.
//
// Parameters
//   EXPECTED_RESULTS : results that complete a run (1 .. 2^CNT_W-1)
//   TIMEOUT_CYCLES   : max cycles in any waiting state (>= 2)
//   CNT_W            : width of result and timeout counters
//
// Ports
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   start            : arm pulse, honoured in IDLE or DONE only
//   ready            : wrapper ready/idle
//   key_exp_done     : key expansion complete (level)
//   result_valid     : result valid (level, rising edge = new result)
//   result_correct   : result matches, qualified by result_valid rising edge
//   busy             : run in progress
//   done             : run finished, held until re-arm or reset
//   pass             : verdict, meaningful while done=1
//   pass_cnt         : correct results this run (saturating)
//   fail_cnt         : incorrect results this run (saturating)
//   err_code         : first error: 0 none, 1 result before key,
//                      2 key dropped, 3 surplus result, 4 timeout
module aes_status_monitor #(
    parameter int unsigned EXPECTED_RESULTS = 1,
    parameter int unsigned TIMEOUT_CYCLES   = 4096,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ready,
    input  logic             key_exp_done,
    input  logic             result_valid,
    input  logic             result_correct,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [2:0]       err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_KEY,
        S_WAIT_RESULT,
        S_WAIT_READY,
        S_DONE
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ORDER   = 3'd1;
    localparam logic [2:0] ERR_KEYDROP = 3'd2;
    localparam logic [2:0] ERR_SURPLUS = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'(EXPECTED_RESULTS);
    localparam logic [CNT_W:0]   EXP_TOT  = (CNT_W+1)'(EXPECTED_RESULTS);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             rv_q;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] pass_cnt_d, fail_cnt_d;
    logic [2:0]       err_d;
    logic             pass_d, busy_d, done_d;

    logic             rise;
    logic             tmo_hit;
    logic [CNT_W-1:0] pc_inc, fc_inc;
    logic [CNT_W:0]   total_inc;
    logic             reach;

    // rv_q follows result_valid every cycle, so at arm it already holds the
    // current level and a level that is high at arm is not seen as an edge.
    assign rise    = result_valid & ~rv_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    // Counter values if this cycle's rising edge is counted (saturating).
    always_comb begin
        pc_inc = pass_cnt;
        fc_inc = fail_cnt;
        if (rise) begin
            if (result_correct) begin
                if (pass_cnt != '1) pc_inc = pass_cnt + 1'b1;
            end else begin
                if (fail_cnt != '1) fc_inc = fail_cnt + 1'b1;
            end
        end
        total_inc = {1'b0, pc_inc} + {1'b0, fc_inc};
        reach     = (total_inc >= EXP_TOT);
    end

    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt;
        fail_cnt_d = fail_cnt;
        err_d      = err_code;
        tmo_d      = tmo_q;
        pass_d     = pass;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_WAIT_KEY;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    err_d      = ERR_NONE;
                    tmo_d      = '0;
                    pass_d     = 1'b0;
                end
            end
            S_WAIT_KEY: begin
                if (key_exp_done) begin
                    // A result in the same cycle as key completion is legal.
                    pass_cnt_d = pc_inc;
                    fail_cnt_d = fc_inc;
                    tmo_d      = '0;
                    state_d    = reach ? S_WAIT_READY : S_WAIT_RESULT;
                end else if (rise) begin
                    state_d = S_DONE;
                    err_d   = ERR_ORDER;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_RESULT: begin
                // A same-cycle result is counted even when key drop wins.
                pass_cnt_d = pc_inc;
                fail_cnt_d = fc_inc;
                if (!key_exp_done) begin
                    state_d = S_DONE;
                    err_d   = ERR_KEYDROP;
                end else if (rise) begin
                    tmo_d = '0;
                    if (reach) state_d = S_WAIT_READY;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_READY: begin
                if (rise) begin
                    state_d = S_DONE;
                    err_d   = ERR_SURPLUS;
                end else if (ready) begin
                    state_d = S_DONE;
                    pass_d  = (fail_cnt == '0) && (pass_cnt == EXP_CNT);
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so that done, busy,
        // pass and err_code all change on the same edge.
        busy_d = (state_d == S_WAIT_KEY) || (state_d == S_WAIT_RESULT) ||
                 (state_d == S_WAIT_READY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rv_q     <= 1'b0;
            tmo_q    <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_code <= ERR_NONE;
            pass     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rv_q     <= result_valid;
            tmo_q    <= tmo_d;
            pass_cnt <= pass_cnt_d;
            fail_cnt <= fail_cnt_d;
            err_code <= err_d;
            pass     <= pass_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_status_monitor.sv
// tb_aes_status_monitor
//   Directed bench for aes_status_monitor. Two instances share all inputs:
//   dut_a runs with one expected result, dut_b with three; both time out
//   after 16 cycles. A cycle table drives the single-result scenarios; short
//   hand-written sequences cover timeout, surplus, reset and re-arm corners.
module tb_aes_status_monitor;

    logic clk = 1'b0;
    logic reset, start, ready, key_exp_done, result_valid, result_correct;

    logic        a_busy, a_done, a_pass;
    logic [15:0] a_pc, a_fc;
    logic [2:0]  a_err;
    logic        b_busy, b_done, b_pass;
    logic [15:0] b_pc, b_fc;
    logic [2:0]  b_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_status_monitor #(
        .EXPECTED_RESULTS(1),
        .TIMEOUT_CYCLES  (16),
        .CNT_W           (16)
    ) dut_a (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ready         (ready),
        .key_exp_done  (key_exp_done),
        .result_valid  (result_valid),
        .result_correct(result_correct),
        .busy          (a_busy),
        .done          (a_done),
        .pass          (a_pass),
        .pass_cnt      (a_pc),
        .fail_cnt      (a_fc),
        .err_code      (a_err)
    );

    aes_status_monitor #(
        .EXPECTED_RESULTS(3),
        .TIMEOUT_CYCLES  (16),
        .CNT_W           (16)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ready         (ready),
        .key_exp_done  (key_exp_done),
        .result_valid  (result_valid),
        .result_correct(result_correct),
        .busy          (b_busy),
        .done          (b_done),
        .pass          (b_pass),
        .pass_cnt      (b_pc),
        .fail_cnt      (b_fc),
        .err_code      (b_err)
    );

    typedef struct {
        int          n;
        logic        start, ready, key, rv, rc;
        logic        busy, done, pass;
        logic [15:0] pc, fc;
        logic [2:0]  err;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input int n, input logic s, input logic rdy,
                                input logic k, input logic rv, input logic rc,
                                input logic b, input logic d, input logic p,
                                input int pc, input int fc, input int e);
        vec_t v;
        v.n = n; v.start = s; v.ready = rdy; v.key = k; v.rv = rv; v.rc = rc;
        v.busy = b; v.done = d; v.pass = p;
        v.pc = pc[15:0]; v.fc = fc[15:0]; v.err = e[2:0];
        return v;
    endfunction

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic ab, input logic b,
                       input logic d, input logic p, input int pc, input int fc,
                       input int e);
        logic        ob, od, op;
        logic [15:0] opc, ofc, epc, efc;
        logic [2:0]  oe, ee;
        epc = pc[15:0]; efc = fc[15:0]; ee = e[2:0];
        if (ab) begin
            ob = b_busy; od = b_done; op = b_pass; opc = b_pc; ofc = b_fc; oe = b_err;
        end else begin
            ob = a_busy; od = a_done; op = a_pass; opc = a_pc; ofc = a_fc; oe = a_err;
        end
        n_checks++;
        if (ob !== b || od !== d || op !== p || opc !== epc || ofc !== efc || oe !== ee) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b done=%0b pass=%0b pc=%0d fc=%0d err=%0d, want busy=%0b done=%0b pass=%0b pc=%0d fc=%0d err=%0d",
                     nm, ob, od, op, opc, ofc, oe, b, d, p, epc, efc, ee);
        end
    endtask

    task automatic drive(input logic s, input logic rdy, input logic k,
                         input logic rv, input logic rc);
        start = s; ready = rdy; key_exp_done = k; result_valid = rv; result_correct = rc;
    endtask

    initial begin
        // Single-result scenarios on dut_a:
        //           n  st rdy key rv rc   busy done pass pc fc err
        tbl[0]  = mk(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0); // arm
        tbl[1]  = mk(4, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0); // key at +5
        tbl[3]  = mk(9, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 1, 1, 1,   1, 0, 0, 1, 0, 0); // result at +10
        tbl[5]  = mk(1, 0, 0, 1, 1, 1,   1, 0, 0, 1, 0, 0);
        tbl[6]  = mk(1, 0, 1, 1, 1, 1,   0, 1, 1, 1, 0, 0); // ready -> pass
        tbl[7]  = mk(3, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0); // held
        tbl[8]  = mk(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0); // re-arm from DONE
        tbl[9]  = mk(1, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 1, 1, 0,   1, 0, 0, 0, 1, 0); // wrong result
        tbl[11] = mk(1, 0, 1, 1, 1, 0,   0, 1, 0, 0, 1, 0);
        tbl[12] = mk(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0, 1); // result before key
        tbl[14] = mk(2, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        tbl[15] = mk(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[16] = mk(2, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 0, 1, 1,   0, 1, 0, 1, 0, 2); // key drop + result
        tbl[18] = mk(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 0, 0, 1, 1, 1,   1, 0, 0, 1, 0, 0); // key+result same cycle
        tbl[20] = mk(1, 0, 1, 1, 1, 1,   0, 1, 1, 1, 0, 0);

        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        step(2);
        chk("reset_a", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_b", 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].start, tbl[i].ready, tbl[i].key, tbl[i].rv, tbl[i].rc);
            step(tbl[i].n);
            chk($sformatf("tbl[%0d]", i), 0, tbl[i].busy, tbl[i].done, tbl[i].pass,
                int'(tbl[i].pc), int'(tbl[i].fc), int'(tbl[i].err));
        end

        // Timeout in WAIT_KEY: done exactly 16 cycles after entry.
        drive(1, 0, 0, 0, 0); step(1);
        drive(0, 0, 0, 0, 0); step(15);
        chk("tmo_key_before", 0, 1, 0, 0, 0, 0, 0);
        step(1);
        chk("tmo_key_fire", 0, 0, 1, 0, 0, 0, 4);

        // Key arriving on the last allowed cycle beats the timeout; the
        // following WAIT_RESULT then times out on its own 16-cycle budget.
        drive(1, 0, 0, 0, 0); step(1);
        drive(0, 0, 0, 0, 0); step(15);
        key_exp_done = 1'b1; step(1);
        chk("tmo_key_late", 0, 1, 0, 0, 0, 0, 0);
        step(15);
        chk("tmo_res_before", 0, 1, 0, 0, 0, 0, 0);
        step(1);
        chk("tmo_res_fire", 0, 0, 1, 0, 0, 0, 4);

        // Three results then a surplus on dut_b.
        drive(0, 0, 0, 0, 0); reset = 1'b1; step(1); reset = 1'b0;
        drive(1, 0, 0, 0, 0); step(1);
        drive(0, 0, 1, 0, 0); step(1);
        for (int p = 1; p <= 3; p++) begin
            drive(0, 0, 1, 1, 1); step(1);
            chk($sformatf("multi_%0d", p), 1, 1, 0, 0, p, 0, 0);
            drive(0, 0, 1, 0, 0); step(1);
        end
        drive(0, 0, 1, 1, 1); step(1);
        chk("surplus", 1, 0, 1, 0, 3, 0, 3);

        // Reset in the middle of WAIT_RESULT.
        drive(0, 0, 0, 0, 0); reset = 1'b1; step(1); reset = 1'b0;
        drive(1, 0, 0, 0, 0); step(1);
        drive(0, 0, 1, 0, 0); step(1);
        drive(0, 0, 1, 1, 1); step(1);
        chk("mid_run_b", 1, 1, 0, 0, 1, 0, 0);
        reset = 1'b1; step(1); reset = 1'b0;
        chk("mid_reset_b", 1, 0, 0, 0, 0, 0, 0);
        chk("mid_reset_a", 0, 0, 0, 0, 0, 0, 0);

        // Re-arm from DONE while result_valid is held high.
        drive(1, 0, 0, 0, 0); step(1);
        drive(0, 0, 0, 1, 1); step(1);
        chk("rearm_pre", 0, 0, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 1); step(1);
        chk("rearm_arm", 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1); step(3);
        chk("rearm_held", 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0); step(1);
        drive(0, 0, 1, 1, 1); step(1);
        chk("rearm_count", 0, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 1, 1, 1); step(1);
        chk("rearm_pass", 0, 0, 1, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
